// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for a simple dual-port BRAM: the write port (A) and the
// read port (B) each carry their own round-robin priority bit.
module bram_port_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rq0_valid,
   input  logic                  rq0_we,
   input  logic [ADDR_WIDTH-1:0] rq0_addr,
   input  logic [DATA_WIDTH-1:0] rq0_wdata,
   output logic                  rq0_ready,
   output logic                  rq0_rsp_valid,
   output logic [DATA_WIDTH-1:0] rq0_rsp_rdata,
   input  logic                  rq1_valid,
   input  logic                  rq1_we,
   input  logic [ADDR_WIDTH-1:0] rq1_addr,
   input  logic [DATA_WIDTH-1:0] rq1_wdata,
   output logic                  rq1_ready,
   output logic                  rq1_rsp_valid,
   output logic [DATA_WIDTH-1:0] rq1_rsp_rdata,
   output logic                  bram_we_a,
   output logic [ADDR_WIDTH-1:0] bram_addr_a,
   output logic [DATA_WIDTH-1:0] bram_din_a,
   output logic [ADDR_WIDTH-1:0] bram_addr_b,
   input  logic [DATA_WIDTH-1:0] bram_dout_b
);

   logic                  wr_c0, wr_c1, rd_c0, rd_c1;
   logic                  wr_g0, wr_g1, rd_g0, rd_g1;
   logic                  wr_prio, rd_prio;
   logic [ADDR_WIDTH-1:0] addr_b_p1;
   logic                  rsp_vld0_p1, rsp_vld1_p1;

   // Grant decode: a prio bit of 0 favours requester 0; nothing is granted in reset.
   always_comb begin
      wr_c0 = rq0_valid & rq0_we;
      wr_c1 = rq1_valid & rq1_we;
      rd_c0 = rq0_valid & ~rq0_we;
      rd_c1 = rq1_valid & ~rq1_we;
      wr_g0 = ~rst & wr_c0 & (~wr_c1 | ~wr_prio);
      wr_g1 = ~rst & wr_c1 & (~wr_c0 | wr_prio);
      rd_g0 = ~rst & rd_c0 & (~rd_c1 | ~rd_prio);
      rd_g1 = ~rst & rd_c1 & (~rd_c0 | rd_prio);
   end

   assign rq0_ready   = wr_g0 | rd_g0;
   assign rq1_ready   = wr_g1 | rd_g1;

   assign bram_we_a   = wr_g0 | wr_g1;
   assign bram_addr_a = wr_g1 ? rq1_addr  : rq0_addr;
   assign bram_din_a  = wr_g1 ? rq1_wdata : rq0_wdata;
   assign bram_addr_b = rd_g0 ? rq0_addr : (rd_g1 ? rq1_addr : addr_b_p1);

   // Responses owed across a reset assertion are masked here, not just cleared at the edge.
   assign rq0_rsp_valid = rsp_vld0_p1 & ~rst;
   assign rq1_rsp_valid = rsp_vld1_p1 & ~rst;
   assign rq0_rsp_rdata = bram_dout_b;
   assign rq1_rsp_rdata = bram_dout_b;

   // Stage p1: priority update, read-address hold and response valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_prio     <= 1'b0;
         rd_prio     <= 1'b0;
         addr_b_p1   <= '0;
         rsp_vld0_p1 <= 1'b0;
         rsp_vld1_p1 <= 1'b0;
      end else begin
         if (wr_g0)
            wr_prio <= 1'b1;
         else if (wr_g1)
            wr_prio <= 1'b0;
         if (rd_g0)
            rd_prio <= 1'b1;
         else if (rd_g1)
            rd_prio <= 1'b0;
         if (rd_g0 | rd_g1)
            addr_b_p1 <= bram_addr_b;
         rsp_vld0_p1 <= rd_g0;
         rsp_vld1_p1 <= rd_g1;
      end
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a read-first BRAM model attached.
module tb_bram_port_arbiter;

   localparam int DW = 8;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          rq0_valid, rq0_we, rq0_ready, rq0_rsp_valid;
   logic [AW-1:0] rq0_addr;
   logic [DW-1:0] rq0_wdata, rq0_rsp_rdata;
   logic          rq1_valid, rq1_we, rq1_ready, rq1_rsp_valid;
   logic [AW-1:0] rq1_addr;
   logic [DW-1:0] rq1_wdata, rq1_rsp_rdata;
   logic          bram_we_a;
   logic [AW-1:0] bram_addr_a, bram_addr_b;
   logic [DW-1:0] bram_din_a, bram_dout_b;

   bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .rq0_valid(rq0_valid), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
      .rq0_ready(rq0_ready), .rq0_rsp_valid(rq0_rsp_valid), .rq0_rsp_rdata(rq0_rsp_rdata),
      .rq1_valid(rq1_valid), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
      .rq1_ready(rq1_ready), .rq1_rsp_valid(rq1_rsp_valid), .rq1_rsp_rdata(rq1_rsp_rdata),
      .bram_we_a(bram_we_a), .bram_addr_a(bram_addr_a), .bram_din_a(bram_din_a),
      .bram_addr_b(bram_addr_b), .bram_dout_b(bram_dout_b)
   );

   always #5 clk = ~clk;

   // Read-first BRAM: the registered read sees the contents before a same-edge write.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
   always @(posedge clk) begin
      if (bram_we_a) mem[bram_addr_a] <= bram_din_a;
      bram_dout_b <= mem[bram_addr_b];
   end

   typedef struct packed {
      logic          req;
      logic [DW-1:0] data;
   } rsp_t;

   rsp_t          exp_q[$];
   logic [DW-1:0] m_mem [0:(1<<AW)-1];
   logic          m_wr_prio, m_rd_prio;
   logic [AW-1:0] m_addr_b;
   int            n_cmp = 0;
   int            n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle with the currently driven inputs; one-shot requests drop once granted.
   task automatic tick();
      logic gw0, gw1, gr0, gr1, ev0, ev1;
      logic [AW-1:0] exp_ab;
      #1;
      gw0 = 1'b0; gw1 = 1'b0; gr0 = 1'b0; gr1 = 1'b0;
      if (!rst) begin
         gw0 = rq0_valid && rq0_we  && !(rq1_valid && rq1_we  && m_wr_prio);
         gw1 = rq1_valid && rq1_we  && !(rq0_valid && rq0_we  && !m_wr_prio);
         gr0 = rq0_valid && !rq0_we && !(rq1_valid && !rq1_we && m_rd_prio);
         gr1 = rq1_valid && !rq1_we && !(rq0_valid && !rq0_we && !m_rd_prio);
      end
      ev0 = !rst && exp_q.size() > 0 && exp_q[0].req == 1'b0;
      ev1 = !rst && exp_q.size() > 0 && exp_q[0].req == 1'b1;
      check_eq("rsp_valid0", rq0_rsp_valid, ev0);
      check_eq("rsp_valid1", rq1_rsp_valid, ev1);
      if (ev0 && rq0_rsp_valid) check_eq("rsp_rdata0", rq0_rsp_rdata, exp_q[0].data);
      if (ev1 && rq1_rsp_valid) check_eq("rsp_rdata1", rq1_rsp_rdata, exp_q[0].data);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      check_eq("ready0", rq0_ready, gw0 | gr0);
      check_eq("ready1", rq1_ready, gw1 | gr1);
      check_eq("we_a", bram_we_a, gw0 | gw1);
      if (gw0 | gw1) begin
         check_eq("addr_a", bram_addr_a, gw1 ? rq1_addr : rq0_addr);
         check_eq("din_a", bram_din_a, gw1 ? rq1_wdata : rq0_wdata);
      end
      exp_ab = gr0 ? rq0_addr : (gr1 ? rq1_addr : m_addr_b);
      if (!rst) check_eq("addr_b", bram_addr_b, exp_ab);
      if (gr0) exp_q.push_back({1'b0, m_mem[rq0_addr]});
      if (gr1) exp_q.push_back({1'b1, m_mem[rq1_addr]});
      if (gw0) m_mem[rq0_addr] = rq0_wdata;
      if (gw1) m_mem[rq1_addr] = rq1_wdata;
      if (rst) begin
         m_wr_prio = 1'b0; m_rd_prio = 1'b0; m_addr_b = '0;
         exp_q.delete();
      end else begin
         if (gw0) m_wr_prio = 1'b1; else if (gw1) m_wr_prio = 1'b0;
         if (gr0) m_rd_prio = 1'b1; else if (gr1) m_rd_prio = 1'b0;
         m_addr_b = exp_ab;
      end
      @(negedge clk);
      if (gw0 | gr0) rq0_valid = 1'b0;
      if (gw1 | gr1) rq1_valid = 1'b0;
   endtask

   task automatic req0(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      rq0_valid = 1'b1; rq0_we = we; rq0_addr = a; rq0_wdata = d;
   endtask

   task automatic req1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      rq1_valid = 1'b1; rq1_we = we; rq1_addr = a; rq1_wdata = d;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 4 && (rq0_valid || rq1_valid); i++) tick();
      check_eq(tag, {rq0_valid, rq1_valid}, 2'b00);
   endtask

   task automatic do_reset();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < (1<<AW); i++) m_mem[i] = '0;
      m_wr_prio = 1'b0; m_rd_prio = 1'b0; m_addr_b = '0;
      rst = 1'b1;
      rq0_valid = 1'b0; rq0_we = 1'b0; rq0_addr = '0; rq0_wdata = '0;
      rq1_valid = 1'b0; rq1_we = 1'b0; rq1_addr = '0; rq1_wdata = '0;
      @(negedge clk);

      // Requests held during reset must not be granted.
      req0(1'b1, 10'h3FF, 8'hEE); req1(1'b0, 10'h3FF, 8'h00);
      tick(); tick();
      check_eq("reset_hold", {rq0_valid, rq1_valid}, 2'b11);
      rq0_valid = 1'b0; rq1_valid = 1'b0;
      rst = 1'b0;

      // Single write then read-back.
      req0(1'b1, 10'h005, 8'hA5); tick();
      req0(1'b0, 10'h005, 8'h00); tick();
      tick();

      // Write contention from reset: rq0 then rq1, last writer wins.
      do_reset();
      req0(1'b1, 10'h010, 8'h11); req1(1'b1, 10'h010, 8'h22);
      drain("wr_contend_drain");
      req0(1'b0, 10'h010, 8'h00); tick();
      tick();

      // Continuous read contention: grants alternate starting with rq0.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req0(1'b0, 10'h010, 8'h00); req1(1'b0, 10'h005, 8'h00);
         tick();
      end
      rq0_valid = 1'b0; rq1_valid = 1'b0;
      tick();

      // Concurrent write and read to one address: read-first, then new data.
      req0(1'b1, 10'h020, 8'h7E); req1(1'b0, 10'h020, 8'h00); tick();
      check_eq("concurrent_both", {rq0_valid, rq1_valid}, 2'b00);
      req1(1'b0, 10'h020, 8'h00); tick();
      tick();

      // Reset right after an accepted read drops the owed response.
      req0(1'b1, 10'h030, 8'h55); req1(1'b0, 10'h020, 8'h00); tick();
      rst = 1'b1; tick(); rst = 1'b0;
      req0(1'b1, 10'h040, 8'h01); req1(1'b1, 10'h040, 8'h02); tick();
      check_eq("post_rst_wr_prio", {rq0_valid, rq1_valid}, 2'b01);
      rq1_valid = 1'b0;
      req0(1'b0, 10'h040, 8'h00); req1(1'b0, 10'h005, 8'h00); tick();
      check_eq("post_rst_rd_prio", {rq0_valid, rq1_valid}, 2'b01);
      drain("post_rst_drain");

      // Idle: nothing granted and the read address holds.
      for (int i = 0; i < 5; i++) tick();
      check_eq("idle_addr_b", bram_addr_b, 10'h005);
      check_eq("queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one simple dual-port BRAM between two requesters: requester 0 is the CPU MMIO path, requester 1 is the accelerator datapath.
- The BRAM has one write-only port (A) and one read-only port (B), each with 1-cycle read latency. The arbiter arbitrates each port independently with round-robin priority.
- In one cycle the arbiter can accept one write from one requester and one read from the other.
- Read data returns on a fixed-latency response channel with no backpressure.

Parameters:
- DATA_WIDTH, 8, BRAM word width.
- ADDR_WIDTH, 10, BRAM address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rq0_valid  in  1  requester 0 has a request.
- rq0_we  in  1  1 = write, 0 = read.
- rq0_addr  in  ADDR_WIDTH  request address.
- rq0_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rq0_ready  out  1  request accepted this cycle.
- rq0_rsp_valid  out  1  read data valid.
- rq0_rsp_rdata  out  DATA_WIDTH  read data.
- rq1_valid, rq1_we, rq1_addr, rq1_wdata, rq1_ready, rq1_rsp_valid, rq1_rsp_rdata  same widths and meanings as requester 0, for requester 1.
- bram_we_a  out  1  BRAM port A write enable.
- bram_addr_a  out  ADDR_WIDTH  BRAM write address.
- bram_din_a  out  DATA_WIDTH  BRAM write data.
- bram_addr_b  out  ADDR_WIDTH  BRAM read address.
- bram_dout_b  in  DATA_WIDTH  BRAM read data; registered in the BRAM, valid 1 cycle after bram_addr_b is presented.

Behaviour:
- Handshake: a request is accepted in a cycle where rqN_valid=1 and rqN_ready=1. rqN_ready is combinational from valid/we and the arbitration state. A requester holds valid, we, addr and wdata stable until accepted. At most one request per requester is accepted per cycle.
- Write port arbitration:
  - Contenders are requesters with valid=1 and we=1.
  - One contender: it is granted.
  - Both contend: the requester selected by wr_prio wins.
  - wr_prio is a 1-bit register. After any accepted write it is set to the requester that was not granted.
- Read port arbitration: identical scheme with contenders valid=1, we=0, and its own register rd_prio.
- Concurrent grants: a write grant and a read grant to different requesters in the same cycle are both accepted.
- BRAM drive:
  - bram_we_a = 1 only when a write is granted; bram_addr_a and bram_din_a then come from the winner.
  - bram_addr_b comes from the read winner when there is one, otherwise it holds its last granted value (registered mux select).
  - A write is committed at the edge that ends its acceptance cycle. There is no write response.
- Read response:
  - rqN_rsp_valid is a register set to 1 in the cycle immediately after a read by requester N is accepted, for exactly 1 cycle per read.
  - rqN_rsp_rdata = bram_dout_b. It is meaningful only while rqN_rsp_valid=1; otherwise it is don't-care.
  - Latency is 1 cycle. Back-to-back accepted reads give back-to-back responses.
- Same-address collision: a write and a read to the same address accepted in the same cycle. The read returns the pre-write data (read-first); the arbiter does no forwarding. A read accepted in the following cycle returns the new data.
- Reset (while rst=1):
  - rq0_ready=rq1_ready=0; bram_we_a=0.
  - rq0_rsp_valid=rq1_rsp_valid=0, including any response owed for a read accepted the cycle before reset was asserted (that response is dropped).
  - wr_prio=rd_prio=0 (requester 0 favoured); bram_addr_b register = 0.
- No requests: all ready=0, bram_we_a=0, priorities unchanged.
- Priority is unaffected by cycles with no grant; no starvation is possible with two requesters.

Test Plan:
- Reset then a single write: rq0 writes addr 0x005 data 0xA5. Required: rq0_ready=1 the same cycle, bram_we_a=1, addr_a=0x005, din_a=0xA5. Next cycle rq0 reads 0x005 → rq0_rsp_valid=1 one cycle later with rdata=0xA5, and rq1_rsp_valid stays 0.
- Write contention: both requesters hold writes (rq0: 0x010←0x11, rq1: 0x010←0x22) from reset. Required: cycle 1 grants rq0, cycle 2 grants rq1; a final read of 0x010 returns 0x22.
- Read contention: both requesters read continuously for 4 cycles. Required: grants alternate rq0, rq1, rq0, rq1; each rsp_valid pulses 1 cycle after its grant with the correct data.
- Concurrent ops: rq0 writes 0x020←0x7E while rq1 reads 0x020 (old value 0x00). Required: both ready=1 the same cycle; rq1 gets rdata=0x00. rq1 rereads next cycle → 0x7E.
- Reset mid-operation: rq1 read accepted in cycle t, rst=1 in cycle t+1. Required: rq1_rsp_valid=0 at t+1, and after reset both priorities favour rq0 again.
- Idle hold: no requests for 5 cycles. Required: no ready, no bram_we_a, no rsp_valid, and bram_addr_b holds its last granted address.
